// File: rtl/dnn_accel_system_oci_dct_pkg.sv
// Shared types and constants for the OCI compressed-trace sequencer.
// Frame layout is {type[1:0], count[3:0], buffer[29:0]}.
package dnn_accel_system_oci_dct_pkg;

  localparam int DCT_BUF_W = 30;
  localparam int DCT_CNT_W = 4;
  localparam int FRAME_W   = 36;

  localparam logic [1:0] FRAME_TYPE_FULL    = 2'b01;
  localparam logic [1:0] FRAME_TYPE_PARTIAL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } dct_state_e;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0]           ftype,
                                                    input logic [DCT_CNT_W-1:0] cnt,
                                                    input logic [DCT_BUF_W-1:0] buffer);
    return {ftype, cnt, buffer};
  endfunction

endpackage

// File: rtl/dnn_accel_system_oci_dct_frame_reg.sv
// Single-entry valid/ready holding register for outgoing trace frames.
// A load in the same cycle as an accept replaces the frame (back-to-back).
module dnn_accel_system_oci_dct_frame_reg
  import dnn_accel_system_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [FRAME_W-1:0] i_load_data,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [FRAME_W-1:0] o_data,
  output logic               o_free
);

  logic               r_valid;
  logic [FRAME_W-1:0] r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/dnn_accel_system_nios2_qsys_0_oci_dct_ctrl.sv
// OCI compressed-trace sequencer: packs 2-bit atoms into a 30-bit buffer,
// emits full/partial frames and runs the test_ending/test_has_ended flush protocol.
module dnn_accel_system_nios2_qsys_0_oci_dct_ctrl
  import dnn_accel_system_oci_dct_pkg::*;
#(
  parameter int ATOMS_PER_FRAME = 15,
  parameter int DROP_CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  atom_valid,
  input  logic [1:0]            atom,
  input  logic                  flush_req,
  output logic                  frame_valid,
  output logic [FRAME_W-1:0]    frame_data,
  input  logic                  frame_ready,
  output logic [DCT_BUF_W-1:0]  dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
  output logic                  test_ending,
  output logic                  test_has_ended,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(ATOMS_PER_FRAME);

  dct_state_e            r_state;
  logic                  r_test_ending;
  logic                  r_test_has_ended;
  logic [DCT_BUF_W-1:0]  r_dct_buffer;
  logic [DCT_CNT_W-1:0]  r_dct_count;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_count;

  logic                  w_full;
  logic                  w_take;
  logic                  w_load;
  logic                  w_frame_free;
  logic                  w_frame_valid;
  logic [FRAME_W-1:0]    w_frame_data;
  logic [FRAME_W-1:0]    w_load_data;

  assign w_full = (r_dct_count == FULL_CNT);
  // Partial frames only leave during FLUSH; in RUN we wait for a full buffer.
  assign w_take = ((r_state == RUN) && w_full) ||
                  ((r_state == FLUSH) && (r_dct_count != '0));
  assign w_load = w_take && w_frame_free;
  assign w_load_data = make_frame(w_full ? FRAME_TYPE_FULL : FRAME_TYPE_PARTIAL,
                                  r_dct_count, r_dct_buffer);

  dnn_accel_system_oci_dct_frame_reg u_frame_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clr       (!enable),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_ready     (frame_ready),
    .o_valid     (w_frame_valid),
    .o_data      (w_frame_data),
    .o_free      (w_frame_free)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_test_ending    <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else if (!enable) begin
      r_state          <= IDLE;
      r_test_ending    <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= RUN;
        RUN: begin
          if (flush_req) begin
            r_state       <= FLUSH;
            r_test_ending <= 1'b1;
          end
        end
        FLUSH: begin
          if ((r_dct_count == '0) && !w_frame_valid) begin
            r_state          <= DONE;
            r_test_ending    <= 1'b0;
            r_test_has_ended <= 1'b1;
          end
        end
        default: r_state <= DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dct_buffer <= '0;
      r_dct_count  <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (!enable) begin
      r_dct_buffer <= '0;
      r_dct_count  <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_load) begin
        r_dct_buffer <= '0;
        r_dct_count  <= '0;
      end
      if ((r_state == RUN) && atom_valid) begin
        if (w_load) begin
          r_dct_buffer <= {{(DCT_BUF_W-2){1'b0}}, atom};
          r_dct_count  <= DCT_CNT_W'(1);
        end else if (!w_full) begin
          r_dct_buffer <= {r_dct_buffer[DCT_BUF_W-3:0], atom};
          r_dct_count  <= r_dct_count + 1'b1;
        end else begin
          r_overflow <= 1'b1;
          if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
        end
      end
    end
  end

  assign frame_valid    = w_frame_valid;
  assign frame_data     = w_frame_data;
  assign dct_buffer     = r_dct_buffer;
  assign dct_count      = r_dct_count;
  assign test_ending    = r_test_ending;
  assign test_has_ended = r_test_has_ended;
  assign overflow       = r_overflow;
  assign drop_count     = r_drop_count;

endmodule
